// File: rtl/alu_accum_scheduler.sv
// alu_accum_scheduler
//   Drives a 32-bit SIMD-capable ALU through a multi-beat reduction. The
//   reduction can be a sum, XOR, AND or OR. Each operand beat is combined
//   with the running accumulator, which is fed back on Z. The final value
//   is returned on a valid/ready result port.
//
//   Optional build macro: ALU_ACCUM_SCHED_OVF_EN
//     defined   - res_ovf is a sticky carry flag for sum commands.
//     undefined - res_ovf is tied 0 and carry_out is ignored.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   cmd_*                 command port (valid/ready); accepted only in IDLE
//   opnd_valid/ready      operand beat handshake (operands go straight to ALU)
//   ALUMODE/OPMODE/
//   USE_SIMD/CIN/Z        registered ALU controls and accumulator feedback
//   S, carry_out          combinational ALU result
//   res_*                 result port (valid/ready)
module alu_accum_scheduler #(
  parameter int LEN_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_alumode,
  input  logic              cmd_logic_or,
  input  logic              cmd_simd,
  input  logic              cmd_cin,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              opnd_valid,
  output logic              opnd_ready,
  output logic [3:0]        ALUMODE,
  output logic [8:0]        OPMODE,
  output logic              USE_SIMD,
  output logic              CIN,
  output logic [DATA_W-1:0] Z,
  input  logic [DATA_W-1:0] S,
  input  logic              carry_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_ovf
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIRST = 2'd1;
  localparam logic [1:0] ST_ACCUM = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Z mux select: 0 on the first beat (Z ignored), acc on later beats.
  localparam logic [4:0] ZSEL_NONE = 5'b00000;
  localparam logic [4:0] ZSEL_ACC  = 5'b00010;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [3:0]        alumode_q, alumode_d;
  logic [8:0]        opmode_q, opmode_d;
  logic              simd_q, simd_d;
  logic              cin_q, cin_d;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign opnd_ready = (state_q == ST_FIRST) || (state_q == ST_ACCUM);
  assign res_valid  = (state_q == ST_DONE);
  assign res_data   = res_valid ? acc_q : '0;
  assign ALUMODE    = alumode_q;
  assign OPMODE     = opmode_q;
  assign USE_SIMD   = simd_q;
  assign CIN        = cin_q;
  assign Z          = acc_q;

`ifdef ALU_ACCUM_SCHED_OVF_EN
  logic ovf_q, ovf_d;
  assign res_ovf = ovf_q & res_valid;
`else
  logic unused_carry_out;
  assign unused_carry_out = carry_out;
  assign res_ovf = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    alumode_d = alumode_q;
    opmode_d  = opmode_q;
    simd_d    = simd_q;
    cin_d     = cin_q;
`ifdef ALU_ACCUM_SCHED_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_FIRST;
          count_d   = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
          alumode_d = cmd_alumode;
          opmode_d  = {ZSEL_NONE, cmd_logic_or, 3'b101};
          simd_d    = cmd_simd;
          cin_d     = cmd_cin;
          acc_d     = '0;
`ifdef ALU_ACCUM_SCHED_OVF_EN
          ovf_d     = 1'b0;
`endif
        end
      end
      ST_FIRST, ST_ACCUM: begin
        // No opnd_valid: everything holds (stall).
        if (opnd_valid) begin
          acc_d         = S;
          count_d       = count_q - LEN_W'(1);
          cin_d         = 1'b0;             // carry-in applies to beat 1 only
          opmode_d[8:4] = ZSEL_ACC;
          state_d       = (count_q == LEN_W'(1)) ? ST_DONE : ST_ACCUM;
`ifdef ALU_ACCUM_SCHED_OVF_EN
          if (carry_out && (alumode_q[3:2] == 2'b00)) ovf_d = 1'b1;
`endif
        end
      end
      default: begin // ST_DONE
        if (res_ready) begin
          state_d   = ST_IDLE;
          acc_d     = '0;
          count_d   = '0;
          alumode_d = '0;
          opmode_d  = '0;
          simd_d    = 1'b0;
          cin_d     = 1'b0;
`ifdef ALU_ACCUM_SCHED_OVF_EN
          ovf_d     = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      alumode_q <= '0;
      opmode_q  <= '0;
      simd_q    <= 1'b0;
      cin_q     <= 1'b0;
`ifdef ALU_ACCUM_SCHED_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      alumode_q <= alumode_d;
      opmode_q  <= opmode_d;
      simd_q    <= simd_d;
      cin_q     <= cin_d;
`ifdef ALU_ACCUM_SCHED_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_accum_scheduler.sv
module tb_alu_accum_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_alumode;
  logic        cmd_logic_or, cmd_simd, cmd_cin;
  logic [7:0]  cmd_len;
  logic        opnd_valid, opnd_ready;
  logic [3:0]  ALUMODE;
  logic [8:0]  OPMODE;
  logic        USE_SIMD, CIN;
  logic [31:0] Z, S;
  logic        carry_out;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_ovf;

  logic [31:0] X;       // operand beat (W = Y = 0)
  logic [31:0] zsel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_accum_scheduler #(.LEN_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_alumode(cmd_alumode), .cmd_logic_or(cmd_logic_or),
    .cmd_simd(cmd_simd), .cmd_cin(cmd_cin), .cmd_len(cmd_len),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
    .ALUMODE(ALUMODE), .OPMODE(OPMODE), .USE_SIMD(USE_SIMD), .CIN(CIN),
    .Z(Z), .S(S), .carry_out(carry_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf)
  );

  // Small behavioural ALU: Z used only when OPMODE[8:4]=00010.
  always_comb begin
    zsel = (OPMODE[8:4] == 5'b00010) ? Z : 32'h0;
    carry_out = 1'b0;
    S = 32'h0;
    case (ALUMODE[3:2])
      2'b00:   {carry_out, S} = {1'b0, X} + {1'b0, zsel} + {32'h0, CIN};
      2'b01:   S = X ^ zsel;
      2'b11:   S = OPMODE[3] ? (X | zsel) : (X & zsel);
      default: S = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] am, input logic lor, input logic cin,
                          input logic [7:0] len);
    cmd_alumode = am; cmd_logic_or = lor; cmd_cin = cin; cmd_len = len;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] x);
    X = x; opnd_valid = 1'b1;
    tick();
    opnd_valid = 1'b0; X = 32'hDEAD_BEEF;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_alumode = '0; cmd_logic_or = 1'b0;
    cmd_simd = 1'b0; cmd_cin = 1'b0; cmd_len = '0; opnd_valid = 1'b0;
    res_ready = 1'b0; X = '0;
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_opnd_ready", 32'(opnd_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_opmode", 32'(OPMODE), 32'h0);
    chk("rst_z", Z, 32'h0);
    chk("rst_ovf", 32'(res_ovf), 32'd0);
    reset = 1'b0;
    tick();

    // Sum, len 4: 1+2+3+4 = 10
    send_cmd(4'b0000, 1'b0, 1'b0, 8'd4);
    chk("sum_opmode_b1", 32'(OPMODE), 32'h005);
    chk("sum_opnd_ready", 32'(opnd_ready), 32'd1);
    beat(32'd1);
    chk("sum_opmode_b2", 32'(OPMODE), 32'h025);
    beat(32'd2);
    beat(32'd3);
    chk("sum_not_done", 32'(res_valid), 32'd0);
    beat(32'd4);
    chk("sum_res_valid", 32'(res_valid), 32'd1);
    chk("sum_res_data", res_data, 32'd10);
    take_result();
    chk("sum_back_idle", 32'(cmd_ready), 32'd1);

    // len 0 treated as 1 beat, cin=1: 7+1 = 8
    send_cmd(4'b0000, 1'b0, 1'b1, 8'd0);
    chk("len0_cin", 32'(CIN), 32'd1);
    beat(32'd7);
    chk("len0_res_valid", 32'(res_valid), 32'd1);
    chk("len0_res_data", res_data, 32'd8);
    take_result();

    // Stalls: valid pattern 1,0,0,1,0,1 -> 5+6+7 = 18
    send_cmd(4'b0000, 1'b0, 1'b0, 8'd3);
    beat(32'd5);
    tick();
    chk("stall_hold_z", Z, 32'd5);
    tick();
    beat(32'd6);
    tick();
    chk("stall_hold_z2", Z, 32'd11);
    chk("stall_no_done", 32'(res_valid), 32'd0);
    beat(32'd7);
    chk("stall_res_data", res_data, 32'd18);
    chk("stall_opnd_ready", 32'(opnd_ready), 32'd0);

    // Back-pressure with a competing command that must be ignored
    cmd_alumode = 4'b0000; cmd_len = 8'd2; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_res_data", res_data, 32'd18);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    take_result();
    tick();
    chk("bp_no_queue", 32'(opnd_ready), 32'd0);

    // XOR reduction
    send_cmd(4'b0100, 1'b0, 1'b0, 8'd2);
    chk("xor_alumode", 32'(ALUMODE), 32'h4);
    beat(32'hFFFF_0000);
    beat(32'h0F0F_0F0F);
    chk("xor_res_data", res_data, 32'hF0F0_0F0F);
    take_result();

    // OR reduction
    send_cmd(4'b1100, 1'b1, 1'b0, 8'd2);
    chk("or_opmode_b1", 32'(OPMODE), 32'h00D);
    beat(32'h0000_00F0);
    chk("or_opmode_b2", 32'(OPMODE), 32'h02D);
    beat(32'h0000_0F00);
    chk("or_res_data", res_data, 32'h0000_0FF0);
    take_result();

    // Async reset during ACCUM
    send_cmd(4'b0000, 1'b0, 1'b0, 8'd3);
    beat(32'd1);
    reset = 1'b1;
    #1;
    chk("arst_opnd_ready", 32'(opnd_ready), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("arst_z", Z, 32'h0);
    chk("arst_opmode", 32'(OPMODE), 32'h0);
    #1 reset = 1'b0;
    tick();

    // len 1 after reset completes normally
    send_cmd(4'b0000, 1'b0, 1'b0, 8'd1);
    beat(32'd9);
    chk("post_rst_res", res_data, 32'd9);
    take_result();

    // Wrap: 0xFFFFFFFF + 1 = 0 with carry
    send_cmd(4'b0000, 1'b0, 1'b0, 8'd2);
    beat(32'hFFFF_FFFF);
    beat(32'd1);
    chk("wrap_res_data", res_data, 32'h0);
`ifdef ALU_ACCUM_SCHED_OVF_EN
    chk("wrap_ovf", 32'(res_ovf), 32'd1);
`else
    chk("wrap_ovf", 32'(res_ovf), 32'd0);
`endif
    take_result();
    chk("final_idle", 32'(cmd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
